tag_lookup_ctrl: RTL and testbench
==================================

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 3, giving the tag RAM index width (DEPTH = 2^AWIDTH).
REQ-002 The block SHALL have parameter DWIDTH, default 14, giving the tag RAM word width: bit DWIDTH-1 = valid, bits DWIDTH-2:0 = tag (TWIDTH = DWIDTH-1).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, lookup request.
REQ-006 The block SHALL have port req_ready, output, 1, lookup accepted when valid&ready.
REQ-007 The block SHALL have port req_index, input, AWIDTH, lookup set index.
REQ-008 The block SHALL have port req_tag, input, TWIDTH, lookup tag.
REQ-009 The block SHALL have port rsp_valid, output, 1, one-cycle lookup result strobe.
REQ-010 The block SHALL have port rsp_hit, output, 1, hit flag, meaningful only with rsp_valid.
REQ-011 The block SHALL have ports fill_valid (input, 1), fill_ready (output, 1), fill_index (input, AWIDTH) and fill_tag (input, TWIDTH), forming the tag-write request.
REQ-012 The block SHALL have port inv_all, input, 1, pulse requesting invalidation of every entry.
REQ-013 The block SHALL have port init_done, output, 1, high when no sweep is active.
REQ-014 The block SHALL have ports ram_addr (output, AWIDTH), ram_din (output, DWIDTH), ram_we (output, 1) and ram_dout (input, DWIDTH), driving a single-port, synchronous-read RAM that latches its read address on the rising edge.

Function
REQ-015 The FSM SHALL have states INIT, IDLE, RD, CMP and WR.
REQ-016 ram_addr, ram_din, ram_we, rsp_valid and rsp_hit SHALL all be registered outputs.
REQ-017 In INIT, a counter SHALL write ram_din=0 to addresses 0..DEPTH-1 on consecutive cycles, with ram_we high for exactly DEPTH cycles.
REQ-018 After the final INIT write, the FSM SHALL go to IDLE and init_done SHALL be high from the next cycle.
REQ-019 req_ready SHALL equal (state==IDLE) & init_done & !fill_valid & !inv_pending.
REQ-020 fill_ready SHALL equal (state==IDLE) & init_done & !inv_pending.
REQ-021 Priority in IDLE SHALL be inv_pending, then fill, then lookup.
REQ-022 Lookup accepted in cycle T: the block SHALL register the tag, drive ram_addr=req_index with ram_we=0 during T+1 (RD), compare in T+2 (CMP), and assert rsp_valid in T+3.
REQ-023 rsp_hit SHALL equal ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0]==stored tag).
REQ-024 The fixed lookup latency SHALL be 3 cycles, and rsp_valid SHALL have no backpressure.
REQ-025 Fill accepted in cycle T: the block SHALL drive ram_addr=fill_index, ram_din={1'b1, fill_tag} and ram_we=1 during T+1 (WR), then return to IDLE in T+2.
REQ-026 A lookup accepted after a fill to the same index SHALL observe the new tag; no bypass is needed, because the write completes before the read.
REQ-027 inv_all seen in any state SHALL set inv_pending.
REQ-028 An in-flight lookup or fill SHALL complete before the block enters INIT.
REQ-029 inv_pending SHALL clear on entry to INIT, and init_done SHALL go low in that same cycle.
REQ-030 Repeated inv_all pulses while pending or in INIT SHALL coalesce; a pulse arriving during INIT SHALL restart the sweep from address 0.
REQ-031 Outside INIT and WR, ram_we SHALL be 0.
REQ-032 Outside a response cycle, rsp_valid SHALL be 0.

Reset
REQ-033 reset SHALL take priority over all other inputs.
REQ-034 Reset SHALL set state=INIT, counter=0, inv_pending=0, init_done=0, rsp_valid=0, rsp_hit=0, ram_we=0, ram_addr=0 and ram_din=0.
REQ-035 Reset asserted mid-lookup or mid-fill SHALL abort the operation and generate no response.
REQ-036 A full INIT sweep SHALL follow every reset deassertion.

Structure
REQ-037 A shared package tag_ctrl_pkg SHALL hold the state encodings, the VALID_BIT position and the TWIDTH derivation.
REQ-038 The INIT sweep counter SHALL be the sub-module tag_init_sweep (inputs start/restart, outputs addr/we/done); no other sub-modules are required.

Verification
REQ-039 Reset, then release (AWIDTH=3) -> ram_we high 8 consecutive cycles with ram_addr 0..7 and ram_din=0; init_done rises after; lookup index 5 tag 0x12 -> rsp_valid at T+3 with rsp_hit=0.
REQ-040 Fill index 2 tag 0x0ABC, then lookup index 2 tag 0x0ABC -> rsp_hit=1; lookup index 2 tag 0x0ABD -> rsp_hit=0.
REQ-041 fill_valid and req_valid high together in IDLE -> fill accepted (req_ready=0), lookup accepted in the cycle after WR and sees the filled tag.
REQ-042 inv_all pulsed during CMP of a lookup -> response still delivered, then an 8-cycle sweep; a lookup of the previously filled entry then misses.
REQ-043 Reset asserted during RD -> no rsp_valid, ram_we=0, full sweep restarts from address 0.
REQ-044 Back-to-back lookups with req_valid held high -> one accept every 3 cycles and exactly one rsp_valid per accept.

Source files
------------

// File: rtl/tag_ctrl_pkg.sv
// Shared definitions for the tag lookup controller.
//   state_e        : controller FSM states
//   tag_width()    : tag field width for a given RAM word width
//   valid_bit()    : position of the valid flag in a RAM word
package tag_ctrl_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRd,
    StCmp,
    StWr
  } state_e;

  // RAM word layout: {valid, tag}; the valid flag is the MSB.
  function automatic int unsigned tag_width(input int unsigned dwidth);
    return dwidth - 1;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned dwidth);
    return dwidth - 1;
  endfunction

endpackage

// File: rtl/tag_init_sweep.sv
// Address sweep counter used to clear the tag RAM.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : high while the controller is sweeping
//   restart      : restart the sweep from address 0
//   addr, we     : address to write and write enable for this cycle
//   done         : last sweep cycle; controller leaves the sweep next cycle
// The count runs one step past the last address so the registered RAM
// outputs of the final write line up with the last sweep cycle.
module tag_init_sweep
  import tag_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              restart,
  output logic [AWIDTH-1:0] addr,
  output logic              we,
  output logic              done
);

  logic [AWIDTH:0] count_q, count_d;

  assign addr = count_q[AWIDTH-1:0];
  assign we   = start & ~count_q[AWIDTH];
  assign done = start & ~restart & count_q[AWIDTH];

  always_comb begin
    count_d = count_q;
    if (!start || restart || done) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{AWIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag RAM controller: clears the RAM after reset or invalidate, services tag
// fills and 3-cycle lookups against a single-port synchronous-read RAM.
//   clock, reset                  : rising-edge clock, synchronous reset
//   req_valid/ready/index/tag     : lookup request
//   rsp_valid, rsp_hit            : one-cycle lookup result
//   fill_valid/ready/index/tag    : tag write request
//   inv_all                       : invalidate every entry (pulse)
//   init_done                     : no sweep active
//   ram_addr/din/we, ram_dout     : tag RAM port (all outputs registered)
module tag_lookup_ctrl
  import tag_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 14,
  localparam int unsigned TWIDTH = tag_width(DWIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [TWIDTH-1:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [AWIDTH-1:0] fill_index,
  input  logic [TWIDTH-1:0] fill_tag,
  input  logic              inv_all,
  output logic              init_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int unsigned VB = valid_bit(DWIDTH);

  state_e            state_q, state_d;
  logic              inv_pending_q, inv_pending_d;
  logic              init_done_q, init_done_d;
  logic [TWIDTH-1:0] tag_q, tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DWIDTH-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;

  logic              sweep_start, sweep_restart, sweep_we, sweep_done;
  logic [AWIDTH-1:0] sweep_addr;
  logic              idle_free;

  assign idle_free  = (state_q == StIdle) & init_done_q & ~inv_pending_q;
  assign fill_ready = idle_free;
  assign req_ready  = idle_free & ~fill_valid;

  assign sweep_start   = (state_q == StInit);
  assign sweep_restart = sweep_start & inv_all;

  tag_init_sweep #(
    .AWIDTH (AWIDTH)
  ) u_sweep (
    .clock   (clock),
    .reset   (reset),
    .start   (sweep_start),
    .restart (sweep_restart),
    .addr    (sweep_addr),
    .we      (sweep_we),
    .done    (sweep_done)
  );

  always_comb begin
    state_d       = state_q;
    inv_pending_d = inv_pending_q | inv_all;
    init_done_d   = init_done_q;
    tag_d         = tag_q;
    rsp_valid_d   = 1'b0;
    rsp_hit_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    ram_we_d      = 1'b0;

    unique case (state_q)
      StInit: begin
        // Invalidates arriving mid-sweep restart it rather than queueing.
        inv_pending_d = 1'b0;
        ram_addr_d    = sweep_addr;
        ram_din_d     = '0;
        ram_we_d      = sweep_we;
        if (sweep_done) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (inv_pending_q) begin
          state_d       = StInit;
          inv_pending_d = 1'b0;
          init_done_d   = 1'b0;
        end else if (fill_valid && fill_ready) begin
          state_d    = StWr;
          ram_addr_d = fill_index;
          ram_din_d  = {1'b1, fill_tag};
          ram_we_d   = 1'b1;
        end else if (req_valid && req_ready) begin
          state_d    = StRd;
          ram_addr_d = req_index;
          tag_d      = req_tag;
        end
      end
      StRd: begin
        state_d = StCmp;
      end
      StCmp: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = ram_dout[VB] & (ram_dout[TWIDTH-1:0] == tag_q);
      end
      StWr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StInit;
      inv_pending_q <= 1'b0;
      init_done_q   <= 1'b0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      inv_pending_q <= inv_pending_d;
      init_done_q   <= init_done_d;
      tag_q         <= tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hit_q     <= rsp_hit_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: bench-side tag RAM, a tag-store model that
// predicts every lookup result, and directed scenarios with literal results.
module tb_tag_lookup_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 14;
  localparam int TW    = 13;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_index = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid, rsp_hit;
  logic          fill_valid = 1'b0, fill_ready;
  logic [AW-1:0] fill_index = '0;
  logic [TW-1:0] fill_tag = '0;
  logic          inv_all = 1'b0;
  logic          init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;

  tag_lookup_ctrl #(
    .AWIDTH (AW),
    .DWIDTH (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_index (fill_index),
    .fill_tag   (fill_tag),
    .inv_all    (inv_all),
    .init_done  (init_done),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tag-store model: what each index holds, and the response each accepted
  // lookup must produce three cycles after its handshake.
  bit            m_valid [DEPTH];
  logic [TW-1:0] m_tag   [DEPTH];
  typedef struct {int due; bit hit;} rsp_t;
  rsp_t exp_q[$];

  initial begin
    bit want;
    forever begin
      @(negedge clock);
      want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", rsp_valid, want);
      if (want) begin
        chk("rsp_hit_model", rsp_hit, exp_q[0].hit);
        void'(exp_q.pop_front());
      end
      if (reset) begin
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else begin
        if (inv_all) for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        if (fill_valid && fill_ready) begin
          m_valid[fill_index] = 1'b1;
          m_tag[fill_index]   = fill_tag;
        end
        if (req_valid && req_ready)
          exp_q.push_back('{due: cyc + 3,
                            hit: m_valid[req_index] && (m_tag[req_index] == req_tag)});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits for req_ready at negedges; returns the acceptance cycle.
  task automatic wait_accept(input string name, output int t_acc);
    bit got = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (req_ready) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    if (!got) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string name, input int t_acc, input bit exp_hit);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid) got = 1'b1;
    end
    chk({name, "_rsp_seen"}, got, 1);
    if (got) begin
      chk({name, "_latency"}, cyc - t_acc, 3);
      chk({name, "_hit"}, rsp_hit, exp_hit);
    end
    step();
  endtask

  task automatic lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                        input bit exp_hit, input string name);
    int t;
    req_valid = 1'b1;
    req_index = idx;
    req_tag   = tag;
    wait_accept(name, t);
    step();
    req_valid = 1'b0;
    if (t >= 0) wait_rsp(name, t, exp_hit);
  endtask

  task automatic fill(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
    bit got = 1'b0;
    fill_valid = 1'b1;
    fill_index = idx;
    fill_tag   = tag;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (fill_ready) got = 1'b1;
    end
    if (!got) chk("fill_accept_timeout", 0, 1);
    step();
    fill_valid = 1'b0;
    step();
  endtask

  // Expects init_done to drop, then eight writes of zero to 0..7 on
  // consecutive cycles, then init_done high in the cycle after the last write.
  task automatic check_sweep(input string name);
    bit low = 1'b0;
    int n = 0, first_we = -1, last_we = -1, done_cyc = -1;
    for (int i = 0; i < 20 && !low; i++) begin
      @(negedge clock);
      if (!init_done) low = 1'b1;
    end
    chk({name, "_init_done_low"}, low, 1);
    for (int i = 0; i < 40; i++) begin
      if (ram_we) begin
        chk({name, "_addr"}, ram_addr, n);
        chk({name, "_din"}, ram_din, 0);
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        n++;
      end
      if (init_done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clock);
    end
    chk({name, "_we_count"}, n, 8);
    chk({name, "_we_span"}, last_we - first_we, 7);
    chk({name, "_done_after_sweep"}, done_cyc - last_we, 1);
    step();
  endtask

  initial begin
    int t, t_f;
    int acc [4];
    int na;

    repeat (3) step();
    @(negedge clock);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fill_ready", fill_ready, 0);
    step();
    reset = 1'b0;
    check_sweep("init");

    lookup(3'd5, 13'h0012, 1'b0, "cold_miss");

    fill(3'd2, 13'h0ABC);
    lookup(3'd2, 13'h0ABC, 1'b1, "fill_hit");
    lookup(3'd2, 13'h0ABD, 1'b0, "tag_diff");

    // Fill and lookup offered together: fill wins, lookup follows WR.
    fill_valid = 1'b1; fill_index = 3'd6; fill_tag = 13'h0155;
    req_valid  = 1'b1; req_index  = 3'd6; req_tag  = 13'h0155;
    @(negedge clock);
    chk("prio_fill_ready", fill_ready, 1);
    chk("prio_req_ready", req_ready, 0);
    t_f = cyc;
    step();
    fill_valid = 1'b0;
    wait_accept("prio", t);
    chk("prio_accept_gap", t - t_f, 2);
    step();
    req_valid = 1'b0;
    wait_rsp("prio", t, 1'b1);

    // Invalidate during CMP: response still delivered, then a full sweep.
    req_valid = 1'b1; req_index = 3'd2; req_tag = 13'h0ABC;
    wait_accept("inv_cmp", t);
    step();
    req_valid = 1'b0;
    step();
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    @(negedge clock);
    chk("inv_cmp_rsp_valid", rsp_valid, 1);
    chk("inv_cmp_rsp_hit", rsp_hit, 1);
    step();
    check_sweep("inv");
    lookup(3'd2, 13'h0ABC, 1'b0, "after_inv");

    // Reset during RD aborts the lookup.
    req_valid = 1'b1; req_index = 3'd3; req_tag = 13'h0001;
    wait_accept("rst_rd", t);
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("rst_rd_rsp_valid", rsp_valid, 0);
    chk("rst_rd_ram_we", ram_we, 0);
    chk("rst_rd_ram_addr", ram_addr, 0);
    step();
    reset = 1'b0;
    check_sweep("rst_rd");

    // Back-to-back lookups with req_valid held high.
    fill(3'd4, 13'h0077);
    req_valid = 1'b1; req_index = 3'd4; req_tag = 13'h0077;
    na = 0;
    for (int i = 0; i < 40 && na < 4; i++) begin
      @(negedge clock);
      if (req_ready) begin
        acc[na] = cyc;
        na++;
      end
    end
    step();
    req_valid = 1'b0;
    chk("b2b_accepts", na, 4);
    if (na == 4)
      for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
